wb_quota_arbiter: RTL and testbench



---
 rtl/wb_quota_arbiter.sv | 161 ++++++++++++++++
 tb/tb_wb_quota_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/wb_quota_arbiter.sv
// Round-robin arbiter for one shared resource; each grant is limited to QUOTA acknowledges.
// Optional watchdog (macro ARB_WATCHDOG_EN) revokes stalled grants and masks the port until it drops its request.
module wb_quota_arbiter #(
  parameter int PORTS   = 4,
  parameter int QUOTA   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PORTS-1:0]         request,
  input  logic [PORTS-1:0]         acknowledge,
  output logic [PORTS-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(PORTS)-1:0] grant_encoded,
  output logic                     timeout_err,
  output logic [$clog2(PORTS)-1:0] timeout_port
);
  localparam int IW = $clog2(PORTS);
  localparam int AW = (QUOTA == 0) ? 1 : $clog2(QUOTA + 1);
  localparam logic [AW-1:0] ACK_MAX = {AW{1'b1}};

  if (PORTS < 2 || PORTS > 32) begin : g_bad_ports
    $error("wb_quota_arbiter: PORTS must be 2..32");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("wb_quota_arbiter: TIMEOUT must be >= 2");
  end

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           r_state, w_state_nxt;
  logic [PORTS-1:0] r_grant, w_grant_nxt;
  logic [IW-1:0]    r_grant_idx, w_grant_idx_nxt;
  logic [IW-1:0]    r_last_ptr, w_last_ptr_nxt;
  logic [AW-1:0]    r_ack_cnt, w_ack_cnt_nxt, w_ack_inc;

  logic [PORTS-1:0] w_elig;
  logic [IW-1:0]    w_win_lo, w_win_hi, w_win;
  logic             w_hit_hi, w_any_elig;
  logic             w_ack_g, w_req_g, w_others;
  logic             w_quota_hit, w_fire;

  // Lowest eligible index above last_ptr, else lowest eligible overall.
  always_comb begin
    w_win_lo = '0;
    w_win_hi = '0;
    w_hit_hi = 1'b0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_win_lo = IW'(i);
        if (i > int'(r_last_ptr)) begin
          w_win_hi = IW'(i);
          w_hit_hi = 1'b1;
        end
      end
    end
  end

  assign w_win       = w_hit_hi ? w_win_hi : w_win_lo;
  assign w_any_elig  = |w_elig;
  assign w_ack_g     = acknowledge[r_grant_idx];
  assign w_req_g     = request[r_grant_idx];
  assign w_others    = |(w_elig & ~r_grant);
  assign w_ack_inc   = (r_ack_cnt == ACK_MAX) ? r_ack_cnt : r_ack_cnt + 1'b1;
  assign w_quota_hit = (QUOTA != 0) && w_ack_g && (r_ack_cnt == AW'(QUOTA - 1));

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_grant_idx_nxt = r_grant_idx;
    w_last_ptr_nxt  = r_last_ptr;
    w_ack_cnt_nxt   = r_ack_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_any_elig) begin
          w_state_nxt          = S_BUSY;
          w_grant_nxt          = '0;
          w_grant_nxt[w_win]   = 1'b1;
          w_grant_idx_nxt      = w_win;
          w_last_ptr_nxt       = w_win;
          w_ack_cnt_nxt        = '0;
        end
      end
      S_BUSY: begin
        if (!w_req_g || (w_quota_hit && w_others) || w_fire) begin
          w_state_nxt     = S_IDLE;
          w_grant_nxt     = '0;
          w_grant_idx_nxt = '0;
          w_ack_cnt_nxt   = '0;
        end else if (w_quota_hit) begin
          // Nobody else is waiting: restart the quota and keep the grant.
          w_ack_cnt_nxt = '0;
        end else if (w_ack_g) begin
          w_ack_cnt_nxt = w_ack_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_last_ptr  <= IW'(PORTS - 1);
      r_ack_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_grant_idx <= w_grant_idx_nxt;
      r_last_ptr  <= w_last_ptr_nxt;
      r_ack_cnt   <= w_ack_cnt_nxt;
    end
  end

  assign grant         = r_grant;
  assign grant_valid   = (r_state == S_BUSY);
  assign grant_encoded = r_grant_idx;

`ifdef ARB_WATCHDOG_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0]    r_idle_cnt;
  logic [PORTS-1:0] r_fault_mask;
  logic             r_timeout_err;
  logic [IW-1:0]    r_timeout_port;

  assign w_elig = request & ~r_fault_mask;
  // An ack in the threshold cycle counts as progress, so it suppresses the fire.
  assign w_fire = (r_state == S_BUSY) && w_req_g && !w_ack_g &&
                  (r_idle_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle_cnt     <= '0;
      r_fault_mask   <= '0;
      r_timeout_err  <= 1'b0;
      r_timeout_port <= '0;
    end else begin
      if (r_state != S_BUSY || w_state_nxt != S_BUSY || w_ack_g)
        r_idle_cnt <= '0;
      else
        r_idle_cnt <= r_idle_cnt + 1'b1;
      r_fault_mask  <= (r_fault_mask | ({PORTS{w_fire}} & r_grant)) & request;
      r_timeout_err <= w_fire;
      if (w_fire)
        r_timeout_port <= r_grant_idx;
    end
  end

  assign timeout_err  = r_timeout_err;
  assign timeout_port = r_timeout_port;
`else
  assign w_elig       = request;
  assign w_fire       = 1'b0;
  assign timeout_err  = 1'b0;
  assign timeout_port = '0;
`endif

endmodule

// File: tb/tb_wb_quota_arbiter.sv
// Bench for wb_quota_arbiter: directed scenarios plus random traffic, all cycles checked against a behavioural model.
module tb_wb_quota_arbiter;
  localparam int P = 4;
  localparam int Q = 8;
  localparam int T = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [P-1:0] request, acknowledge, grant;
  logic         grant_valid, timeout_err;
  logic [1:0]   grant_encoded, timeout_port;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: owner -1 means nothing granted.
  int m_owner, m_last, m_acks, m_idle, m_tport;
  bit m_terr;
  bit m_fault [P];

  wb_quota_arbiter #(.PORTS(P), .QUOTA(Q), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(grant), .grant_valid(grant_valid), .grant_encoded(grant_encoded),
    .timeout_err(timeout_err), .timeout_port(timeout_port)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_elig(input logic [P-1:0] req, input int i);
`ifdef ARB_WATCHDOG_EN
    return req[i] && !m_fault[i];
`else
    return req[i];
`endif
  endfunction

  task automatic model_edge(input logic r, input logic [P-1:0] req, input logic [P-1:0] ack);
    bit el [P];
    bit others;
    bit a;
    int g;
    for (int i = 0; i < P; i++) el[i] = m_elig(req, i);
    if (r) begin
      m_owner = -1; m_last = P - 1; m_acks = 0; m_idle = 0;
      m_terr = 0; m_tport = 0;
      for (int i = 0; i < P; i++) m_fault[i] = 0;
      return;
    end
    m_terr = 0;
    if (m_owner < 0) begin
      for (int k = 1; k <= P; k++) begin
        int p;
        p = (m_last + k) % P;
        if (el[p]) begin
          m_owner = p; m_last = p; m_acks = 0; m_idle = 0;
          break;
        end
      end
    end else begin
      g = m_owner;
      a = ack[g];
      if (a) begin m_acks++; m_idle = 0; end
      else m_idle++;
      others = 0;
      for (int i = 0; i < P; i++) if (i != g && el[i]) others = 1;
      if (!req[g]) m_owner = -1;
      else if (Q != 0 && a && m_acks == Q) begin
        if (others) m_owner = -1;
        else m_acks = 0;
      end
`ifdef ARB_WATCHDOG_EN
      else if (m_idle == T) begin
        m_owner = -1; m_terr = 1; m_tport = g; m_fault[g] = 1;
      end
`endif
    end
    for (int i = 0; i < P; i++) if (!req[i]) m_fault[i] = 0;
  endtask

  task automatic step(input logic r, input logic [P-1:0] req, input logic [P-1:0] ack);
    int e_grant, e_valid, e_enc;
    rst = r; request = req; acknowledge = ack;
    @(posedge clk);
    model_edge(r, req, ack);
    #1;
    e_grant = (m_owner < 0) ? 0 : (1 << m_owner);
    e_valid = (m_owner < 0) ? 0 : 1;
    e_enc   = (m_owner < 0) ? 0 : m_owner;
    check_eq("grant",         32'(grant),         e_grant);
    check_eq("grant_valid",   32'(grant_valid),   e_valid);
    check_eq("grant_encoded", 32'(grant_encoded), e_enc);
    check_eq("timeout_err",   32'(timeout_err),   32'(m_terr));
    check_eq("timeout_port",  32'(timeout_port),  m_tport);
  endtask

  initial begin
    logic [P-1:0] rq;
    logic [P-1:0] ak;
    int           ap;
    rst = 1'b1; request = '0; acknowledge = '0;
    rq = '0;

    step(1, 4'b0000, 4'b0000);
    step(1, 4'b0000, 4'b0000);
    check_eq("rst_outputs", {grant, grant_valid, grant_encoded, timeout_err, timeout_port}, 0);

    // Basic grant, release and one dead cycle.
    step(0, 4'b0101, 4'b0000);
    check_eq("t1_first_grant", 32'(grant), 32'h1);
    step(0, 4'b0100, 4'b0000);
    check_eq("t1_dead_cycle", 32'(grant_valid), 0);
    step(0, 4'b0100, 4'b0000);
    check_eq("t1_second_grant", 32'(grant), 32'h4);

    // Quota rotation between ports 0 and 2.
    step(1, 4'b0000, 4'b0000);
    step(0, 4'b0101, 4'b0000);
    repeat (8) step(0, 4'b0101, 4'b0001);
    check_eq("q_release0", 32'(grant_valid), 0);
    step(0, 4'b0101, 4'b0000);
    check_eq("q_rotate_to2", 32'(grant), 32'h4);
    repeat (8) step(0, 4'b0101, 4'b0100);
    check_eq("q_release2", 32'(grant_valid), 0);
    step(0, 4'b0101, 4'b0000);
    check_eq("q_rotate_to0", 32'(grant), 32'h1);

    // Lone requester keeps the grant across quota boundaries.
    step(1, 4'b0000, 4'b0000);
    step(0, 4'b0010, 4'b0000);
    for (int i = 0; i < 20; i++) begin
      step(0, 4'b0010, 4'b0010);
      check_eq("q_hold_no_gap", 32'(grant_valid), 1);
    end

    // Reset while port 1 holds the grant; then port 0 wins first.
    step(1, 4'b0010, 4'b0000);
    check_eq("rst_mid_grant", {grant, grant_valid, grant_encoded}, 0);
    step(0, 4'b1111, 4'b0000);
    check_eq("rst_port0_first", 32'(grant), 32'h1);

    // Ack and request drop in the same cycle.
    step(1, 4'b0000, 4'b0000);
    step(0, 4'b1000, 4'b0000);
    repeat (15) step(0, 4'b1000, 4'b0000);
    step(0, 4'b1000, 4'b1000);
    check_eq("wd_ack_saves", 32'(grant_valid), 1);
    repeat (15) step(0, 4'b1000, 4'b0000);
    check_eq("wd_counter_restart", 32'(grant), 32'h8);
    step(0, 4'b0000, 4'b1000);
    check_eq("ack_drop_release", {grant_valid, timeout_err}, 0);

`ifdef ARB_WATCHDOG_EN
    // Watchdog fire and fault masking on port 3.
    step(1, 4'b0000, 4'b0000);
    step(0, 4'b1000, 4'b0000);
    check_eq("wd_grant3", 32'(grant), 32'h8);
    repeat (15) step(0, 4'b1000, 4'b0000);
    check_eq("wd_not_yet", 32'(timeout_err), 0);
    step(0, 4'b1000, 4'b0000);
    check_eq("wd_fire", {timeout_err, grant_valid, timeout_port}, {1'b1, 1'b0, 2'd3});
    for (int i = 0; i < 3; i++) begin
      step(0, 4'b1000, 4'b0000);
      check_eq("wd_masked", 32'(grant_valid), 0);
    end
    step(0, 4'b0000, 4'b0000);
    step(0, 4'b1000, 4'b0000);
    check_eq("wd_regrant", 32'(grant), 32'h8);
`endif

    // Random traffic with phases of busy, sparse and absent acknowledges.
    step(1, 4'b0000, 4'b0000);
    for (int c = 0; c < 3000; c++) begin
      case ((c / 200) % 3)
        0:       ap = 50;
        1:       ap = 5;
        default: ap = 0;
      endcase
      for (int i = 0; i < P; i++) begin
        if ($urandom_range((ap == 0) ? 39 : 11) == 0) rq[i] = ~rq[i];
        ak[i] = ($urandom_range(99) < ap);
      end
      step(($urandom_range(499) == 0), rq, ak);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
